// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared constants and state encoding for the instruction-fetch responder.
package imem_responder_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

endpackage

// File: rtl/imem_line_buf.sv
// imem_line_buf: one 64-bit fetch line with tag compare and 32-bit word select.
module imem_line_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  logic        wr_valid_i,
    input  logic        clr_i,
    input  logic [60:0] wr_tag_i,
    input  logic [63:0] wr_data_i,
    input  logic [60:0] tag_i,
    input  logic        sel_i,
    output logic        valid_o,
    output logic        tag_eq_o,
    output logic [31:0] word_o
);

    logic        valid_q;
    logic [60:0] tag_q;
    logic [63:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (wr_i) begin
            valid_q <= wr_valid_i;
            tag_q   <= wr_tag_i;
            data_q  <= wr_data_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign tag_eq_o = tag_q == tag_i;
    assign word_o   = sel_i ? data_q[63:32] : data_q[31:0];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch responder serving hits from a line buffer and refilling misses with a timeout.
// Define IMEM_LINE_BUF_EN to reuse refilled lines; otherwise each refill is delivered once via RESP.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [31:0] NOP_INST       = RV_NOP,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ena,
    input  logic [63:0] inst_addr,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stall,
    output logic        inst_misalign,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_err
);

`ifdef IMEM_LINE_BUF_EN
    localparam bit LINE_BUF = 1'b1;
`else
    localparam bit LINE_BUF = 1'b0;
`endif
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    imem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d, req_d, err_d;
    logic [63:0]   addr_d;
    logic          aligned, fetch, buf_valid, tag_eq, hit, miss, done, tmo;
    logic [31:0]   word;

    assign aligned       = inst_addr[1:0] == 2'b00;
    assign fetch         = inst_ena & aligned;
    // RESP delivers the latched line once, but only to a request that still names it
    assign hit           = fetch & tag_eq & (((state_q == IDLE) & buf_valid) | (state_q == RESP));
    assign miss          = fetch & ~hit & (state_q == IDLE);
    assign done          = (state_q == WAIT) & mem_rvalid;
    assign tmo           = (state_q == WAIT) & ~mem_rvalid & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign inst          = hit ? word : NOP_INST;
    assign stall         = (state_q == WAIT) | (fetch & ~hit);
    assign inst_misalign = inst_ena & ~aligned;

    imem_line_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_i       (done),
        .wr_valid_i (LINE_BUF & ~kill_q & ~flush),
        .clr_i      ((LINE_BUF & flush) | tmo),
        .wr_tag_i   (mem_addr[63:3]),
        .wr_data_i  (mem_rdata),
        .tag_i      (inst_addr[63:3]),
        .sel_i      (inst_addr[2]),
        .valid_o    (buf_valid),
        .tag_eq_o   (tag_eq),
        .word_o     (word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q | flush;
        req_d   = mem_req;
        addr_d  = mem_addr;
        err_d   = 1'b0;
        if (miss) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = {inst_addr[63:3], 3'b000};
            cnt_d   = '0;
            kill_d  = 1'b0;
        end
        if (state_q == WAIT) cnt_d = cnt_q + CW'(1);
        if (done | tmo) begin
            state_d = (done & ~LINE_BUF & ~kill_q & ~flush) ? RESP : IDLE;
            req_d   = 1'b0;
            err_d   = tmo;
        end
        if (state_q == RESP) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kill_q   <= kill_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
            mem_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed fetch scenarios checked against a transaction-level model every cycle.
module tb_imem_responder;

`ifdef IMEM_LINE_BUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif
    localparam int          TO  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, inst_ena, flush, mem_rvalid;
    logic [63:0] inst_addr, mem_addr, mem_rdata;
    logic [31:0] inst;
    logic        stall, inst_misalign, mem_req, mem_err;

    int n_cmp = 0, n_err = 0;
    int lat = 3, req_cnt = 0, refills = 0;
    bit late = 0;

    // model: last refilled line, an in-flight refill, and a one-shot delivery
    bit        line_ok, pend, killed, dlv, perr;
    bit [60:0] line_tag;
    bit [63:0] line_data, paddr;
    int        waited;
    logic [31:0] mi, ci;
    logic        ms, cs;

    imem_responder #(.NOP_INST(NOP), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_ena      (inst_ena),
        .inst_addr     (inst_addr),
        .flush         (flush),
        .inst          (inst),
        .stall         (stall),
        .inst_misalign (inst_misalign),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return (a == 64'h1000) ? 64'hAAAA0013_00100093 : {a[31:0] ^ 32'hC0DE_0000, a[31:0] | 32'h13};
    endfunction

    function automatic void expect_now(output logic [31:0] e_inst, output logic e_stall);
        logic f    = inst_ena && inst_addr[1:0] == 2'b00;
        logic have = f && !pend && (dlv || (LB && line_ok)) && line_tag == inst_addr[63:3];
        e_inst  = have ? (inst_addr[2] ? line_data[63:32] : line_data[31:0]) : NOP;
        e_stall = pend || (f && !have);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic run_until_ready(output int n);
        n = 0;
        while (stall && n < 200) begin
            step();
            peek();
            n++;
        end
        if (stall) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout t=%0t got=stalled exp=ready", $time);
        end
    endtask

    // memory: pulses rvalid on the lat-th cycle of mem_req (lat=0 never answers)
    initial forever begin
        @(posedge clk);
        #2;
        req_cnt    = mem_req ? req_cnt + 1 : 0;
        mem_rvalid = (mem_req && lat != 0 && req_cnt == lat) || late;
        mem_rdata  = mem_word(mem_addr);
        if (mem_req && lat != 0 && req_cnt == lat) refills++;
    end

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            line_ok = 0; pend = 0; killed = 0; dlv = 0; perr = 0; waited = 0; paddr = '0;
        end else begin
            expect_now(mi, ms);
            perr = 0;
            if (pend) begin
                if (mem_rvalid) begin
                    pend      = 0;
                    line_tag  = paddr[63:3];
                    line_data = mem_rdata;
                    line_ok   = LB && !killed && !flush;
                    dlv       = !LB && !killed && !flush;
                end else begin
                    waited++;
                    if (waited == TO) begin
                        pend = 0; perr = 1; line_ok = 0;
                    end else killed = killed | flush;
                end
            end else begin
                if (ms && !dlv) begin
                    pend = 1; paddr = {inst_addr[63:3], 3'b000}; waited = 0; killed = 0;
                end
                dlv = 0;
                if (flush) line_ok = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        expect_now(ci, cs);
        check("inst", inst, ci);
        check("stall", stall, cs);
        check("misalign", inst_misalign, inst_ena && inst_addr[1:0] != 2'b00);
        check("mem_req", mem_req, pend);
        check("mem_addr", mem_addr, paddr);
        check("mem_err", mem_err, perr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; inst_ena = 1'b1; inst_addr = 64'h1000; flush = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1 rst = 1'b1;
        step();
        peek();
        check("rst_stall", stall, 1);
        check("rst_inst", inst, NOP);
        check("rst_mem_req", mem_req, 0);
        step();
        rst = 1'b0;
        peek();
        run_until_ready(n);
        check("t1_stall_cycles", n, 4);
        check("t1_inst", inst, 32'h00100093);
        step();
        inst_addr = 64'h1004;
        peek();
`ifdef IMEM_LINE_BUF_EN
        check("t1_second_half_stall", stall, 0);
`else
        check("t1_second_half_stall", stall, 1);
        run_until_ready(n);
        check("t1_second_refill_cycles", n, 4);
`endif
        check("t1_second_half_inst", inst, 32'hAAAA0013);
        check("t1_refills", refills, LB ? 1 : 2);

        step();
        inst_addr = 64'h2002;
        peek();
        check("mis_flag", inst_misalign, 1);
        check("mis_inst", inst, NOP);
        check("mis_stall", stall, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            peek();
            check("mis_no_req", mem_req, 0);
        end

        step();
        inst_addr = 64'h3000; lat = 2;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        peek();
        check("flush_rvalid_remiss", stall, 1);
        run_until_ready(n);
        check("flush_retry_cycles", n, 3);
        check("flush_retry_inst", inst, 32'h0000_3013);

        step();
        inst_addr = 64'h4000; lat = 0;
        peek();
        n = 0;
        while (!mem_err && n < 200) begin
            step();
            peek();
            n++;
        end
        check("tmo_err_cycle", n, TO + 1);
        check("tmo_req_dropped", mem_req, 0);
        check("tmo_restall", stall, 1);
        lat = 1;
        step();
        peek();
        check("tmo_err_once", mem_err, 0);
        run_until_ready(n);
        check("tmo_retry_cycles", n, 1);

        step();
        inst_addr = 64'h5000; lat = 0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_stall", stall, 1);
        check("arst_inst", inst, NOP);
        step();
        step();
        rst = 1'b0; inst_ena = 1'b0; late = 1'b1;
        step();
        late = 1'b0; inst_ena = 1'b1;
        peek();
        check("late_rvalid_ignored", stall, 1);
        lat = 1;
        run_until_ready(n);
        check("post_reset_refill", n, 2);

        step();
        inst_addr = 64'h6000; lat = 3;
        step();
        inst_addr = 64'h6008;
        peek();
        run_until_ready(n);
        check("addr_change_cycles", n, LB ? 7 : 8);
        check("addr_change_inst", inst, 32'h0000_601B);

        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        peek();
        check("idle_flush_remiss", stall, 1);
        run_until_ready(n);
        step();
        inst_ena = 1'b0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
